// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports with
// write bypass, per-register pending bits, and a one-register-per-cycle clear after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd0,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic                wr0_ok, wr1_ok, rsv_ok;

  // Register 0 is hard-wired to zero when ZERO_REG is set, so its writes and reservations vanish.
  assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  assign ready = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    regs_d    = regs_q;
    pend_d    = pend_q;
    if (rst) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
      pend_d    = '0;
    end else if (state_q == CLEAR) begin
      regs_d[clr_cnt_q] = '0;
      clr_cnt_d         = clr_cnt_q + ADDR_W'(1);
      if (&clr_cnt_q) state_d = RUN;
    end else begin
      // Port 1 is applied last so it wins a same-address collision; the reservation
      // is applied after both writes so it wins over the write's pending clear.
      if (wr0_ok) begin
        regs_d[wa0] = wd0;
        pend_d[wa0] = 1'b0;
      end
      if (wr1_ok) begin
        regs_d[wa1] = wd1;
        pend_d[wa1] = 1'b0;
      end
      if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
    pend_q    <= pend_d;
    regs_q    <= regs_d;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

    // Nothing is visible until the clear sweep is done, so stale contents never leak out.
    always_comb begin
      data = '0;
      pend = 1'b0;
      if (ready && !(ZERO_REG != 0 && ra == '0)) begin
        if (we1 && wa1 == ra) begin
          data = wd1;
        end else if (we0 && wa0 == ra) begin
          data = wd0;
        end else begin
          data = regs_q[ra];
          pend = pend_q[ra];
        end
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data;
    assign rd_pend[gi]                  = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against a simple array-based model of the register file.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pend;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each register will hold once visible, its pending flag,
  // and how many clear cycles remain before the block is usable.
  logic [DW-1:0] mem  [DEPTH];
  logic          pend [DEPTH];
  int            clr_left;
  bit            model_valid = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    rsv_en = 0; rsv_addr = '0;
  endtask

  function automatic void expect_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic p);
    d = '0;
    p = 1'b0;
    if (clr_left == 0 && a != 0) begin
      if (we1 && wa1 == a)      d = wd1;
      else if (we0 && wa0 == a) d = wd0;
      else begin
        d = mem[a];
        p = pend[a];
      end
    end
  endfunction

  task automatic at_neg();
    logic [DW-1:0] ed;
    logic          ep;
    @(negedge clk);
    if (model_valid) begin
      check("ready", {31'd0, ready}, {31'd0, clr_left == 0});
      for (int k = 0; k < NR; k++) begin
        expect_rd(rd_addr[k*AW +: AW], ed, ep);
        check($sformatf("rd_data%0d@%0d", k, rd_addr[k*AW +: AW]), rd_data[k*DW +: DW], ed);
        check($sformatf("rd_pend%0d@%0d", k, rd_addr[k*AW +: AW]), {31'd0, rd_pend[k]}, {31'd0, ep});
      end
    end
  endtask

  task automatic edge_upd();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = '0;
        pend[i] = 1'b0;
      end
      clr_left = DEPTH;
      model_valid = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (we0 && wa0 != 0) begin mem[wa0] = wd0; pend[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin mem[wa1] = wd1; pend[wa1] = 1'b0; end
      if (rsv_en && rsv_addr != 0) pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    at_neg();
    edge_upd();
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    set_rd(0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Clear sweep: exactly DEPTH cycles of ready low; writes during it are ignored.
    for (int i = 0; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = AW'($urandom_range(1, 31)); wd0 = $urandom;
      set_rd(wa0, AW'($urandom));
      at_neg();
      check("clr_ready", {31'd0, ready}, 32'd0);
      check("clr_rd0", rd_data[DW-1:0], 32'd0);
      edge_upd();
    end
    idle();
    at_neg();
    check("ready_up", {31'd0, ready}, 32'd1);
    edge_upd();
    $display("[TB] clear sweep done");
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      at_neg();
      check("zero0", rd_data[DW-1:0], 32'd0);
      check("zero1", rd_data[2*DW-1:DW], 32'd0);
      edge_upd();
    end

    // Dual write to one address: port 1 wins, visible via bypass and afterwards.
    we0 = 1; wa0 = 5; wd0 = 32'hAAAA0000;
    we1 = 1; wa1 = 5; wd1 = 32'h5555FFFF;
    set_rd(5, 5);
    at_neg();
    check("dual_byp", rd_data[DW-1:0], 32'h5555FFFF);
    edge_upd();
    idle();
    at_neg();
    check("dual_after", rd_data[DW-1:0], 32'h5555FFFF);
    edge_upd();
    $display("[TB] dual write addr 5 checked");

    // Reservation, then a write clearing it.
    rsv_en = 1; rsv_addr = 7; set_rd(7, 7);
    step();
    idle();
    at_neg();
    check("rsv7_pend", {31'd0, rd_pend[0]}, 32'd1);
    edge_upd();
    we0 = 1; wa0 = 7; wd0 = 32'h12;
    at_neg();
    check("wr7_pend", {31'd0, rd_pend[0]}, 32'd0);
    check("wr7_data", rd_data[DW-1:0], 32'h12);
    edge_upd();
    idle();
    at_neg();
    check("wr7_pend_after", {31'd0, rd_pend[0]}, 32'd0);
    check("wr7_data_after", rd_data[DW-1:0], 32'h12);
    edge_upd();
    $display("[TB] reserve/write addr 7 checked");

    // Reservation and write together: data stored, pending remains.
    rsv_en = 1; rsv_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h34; set_rd(9, 9);
    step();
    idle();
    at_neg();
    check("rw9_data", rd_data[DW-1:0], 32'h34);
    check("rw9_pend", {31'd0, rd_pend[0]}, 32'd1);
    edge_upd();
    $display("[TB] reserve+write addr 9 checked");

    // Register 0 is immune to writes and reservations.
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; set_rd(0, 0);
    at_neg();
    check("r0_data", rd_data[DW-1:0], 32'd0);
    check("r0_pend", {31'd0, rd_pend[0]}, 32'd0);
    edge_upd();
    idle();
    at_neg();
    check("r0_data_after", rd_data[DW-1:0], 32'd0);
    check("r0_pend_after", {31'd0, rd_pend[0]}, 32'd0);
    edge_upd();
    $display("[TB] zero register checked");

    // Reset in the middle of a clear restarts the full sweep.
    we0 = 1; wa0 = 3; wd0 = 32'h77; set_rd(3, 3);
    step();
    idle();
    at_neg();
    check("r3_set", rd_data[DW-1:0], 32'h77);
    edge_upd();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      check("r3_clr_a", rd_data[DW-1:0], 32'd0);
      edge_upd();
    end
    rst = 1; step(); rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      at_neg();
      check("rerst_ready", {31'd0, ready}, 32'd0);
      check("r3_clr_b", rd_data[DW-1:0], 32'd0);
      edge_upd();
    end
    at_neg();
    check("rerst_ready_up", {31'd0, ready}, 32'd1);
    check("r3_final", rd_data[DW-1:0], 32'd0);
    edge_upd();
    $display("[TB] mid-clear reset checked");

    // Randomized traffic with narrow address ranges to force collisions.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] lim;
      lim = ($urandom_range(0, 1) == 0) ? AW'(7) : AW'(31);
      rst      = ($urandom_range(0, 199) == 0);
      we0      = $urandom_range(0, 1) == 1;
      we1      = $urandom_range(0, 2) == 0;
      wa0      = AW'($urandom_range(0, int'(lim)));
      wa1      = AW'($urandom_range(0, int'(lim)));
      wd0      = $urandom;
      wd1      = $urandom;
      rsv_en   = $urandom_range(0, 2) == 0;
      rsv_addr = AW'($urandom_range(0, int'(lim)));
      set_rd(($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, int'(lim))),
             ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, int'(lim))));
      step();
    end
    rst = 0;
    idle();
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, sets register width in bits.
REQ-002 Parameter ADDR_W, default 5, sets the address width; DEPTH = 2^ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, sets the number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and cannot be written or reserved.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ready  out  1  high when the clear sequence is complete and the block accepts writes and reservations.
REQ-008 we0, we1  in  1 each  write enables, ports 0 and 1.
REQ-009 wa0, wa1  in  ADDR_W each  write addresses.
REQ-010 wd0, wd1  in  DATA_W each  write data.
REQ-011 rsv_en  in  1  reserve request: marks the register at rsv_addr as pending.
REQ-012 rsv_addr  in  ADDR_W  register to reserve.
REQ-013 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-014 rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
REQ-015 rd_pend  out  NUM_RD  per-port pending flag, combinational.

Function
REQ-016 States: CLEAR and RUN; rst forces CLEAR with clr_cnt=0 on the next edge; reset is asserted mid-sequence restarts from clr_cnt=0.
REQ-017 In CLEAR: reg[clr_cnt] <= 0 each cycle and clr_cnt increments; after reg[DEPTH-1] is cleared the FSM enters RUN; the sequence takes exactly DEPTH cycles after rst deasserts.
REQ-018 ready = (state==RUN); in CLEAR: writes and reservations ignored, rd_data = 0, rd_pend = 0.
REQ-019 Pending bits: all cleared on the rst edge (single cycle, not iterative).
REQ-020 RUN write: we0 writes wd0 to reg[wa0]; we1 writes wd1 to reg[wa1]; write takes effect at the edge.
REQ-021 Same-cycle we0 and we1 to the same address: port 1 wins.
REQ-022 With ZERO_REG=1, writes or reservations to address 0 are dropped.
REQ-023 A write clears the pending bit of its address at the same edge.
REQ-024 rsv_en sets pending[rsv_addr] at the edge; rsv_en with a write to the same address in the same cycle: the write data is stored and pending ends set (reservation wins).
REQ-025 Read bypass per port: if we1 and wa1==addr, return wd1; else if we0 and wa0==addr, return wd0; else return reg[addr]; ZERO_REG=1 with addr 0 always returns 0, with no bypass.
REQ-026 rd_pend[k] = pending[addr_k] AND NOT (a qualifying bypass write to addr_k this cycle); rd_pend is 0 for addr 0 when ZERO_REG=1.
REQ-027 Read ports are independent; identical addresses on all ports return identical data.
REQ-028 Zero-latency read: no registered outputs other than ready.

Reset
REQ-029 rst edge: state=CLEAR, clr_cnt=0, ready=0, all pending=0; register contents become 0 within DEPTH cycles after rst deasserts.
REQ-030 Register contents not yet cleared are never visible; reads return 0 until ready=1.

Verification
REQ-031 Defaults, rst 1 cycle, then idle -> ready low for 32 cycles, high on cycle 33; all 32 registers read 0.
REQ-032 RUN, we0 wa0=5 wd0=0xAAAA0000, we1 wa1=5 wd1=0x5555FFFF, rd port 0 addr 5 -> same cycle reads 0x5555FFFF; next cycle reads 0x5555FFFF.
REQ-033 rsv_en addr 7; next cycle rd_pend=1 at addr 7; then we0 wa0=7 wd0=0x12 -> rd_pend=0 and rd_data=0x12 in the same cycle; pending stays clear afterward.
REQ-034 rsv_en addr 9 with we0 wa0=9 wd0=0x34 in the same cycle -> next cycle reads 0x34 with rd_pend=1.
REQ-035 we0 wa0=0 wd0=0xFFFFFFFF, rsv_en addr 0 -> reg 0 reads 0, rd_pend=0 in the same cycle and afterward.
REQ-036 Write reg 3 = 0x77, rst at cycle 10 of a new clear, drop rst -> ready stays low a full 32 cycles; reg 3 reads 0 throughout and after.
